shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle, clocked front end for the 4-bit shift datapath. It accepts a shift job (data word, direction, shift count, clear flag) over a valid/ready handshake and executes it one bit position per clock. While working it drives per-cycle left/right/clear step strobes to the adjacent shift stage, then presents the final word on a valid/ready output port. The block converts the level-triggered left/right/clear controls into a registered, counted, back-pressured operation.

## Interface
- `WIDTH`, default 4: data word width in bits.
- `CNT_W`, default 3: shift-count width. The count range is 0 to 2^CNT_W−1 and may exceed `WIDTH`.
- `clk`  input  1: the block's single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: a job is presented on the `in_*` inputs.
- `in_ready`  output  1: the block can accept a job; high only in IDLE.
- `in_data`  input  WIDTH: operand word.
- `in_dir`  input  1: shift direction; 0 = left (toward MSB), 1 = right (toward LSB).
- `in_count`  input  CNT_W: number of single-bit shifts to perform.
- `in_clear`  input  1: clear the result to zero; overrides `in_count` and `in_dir`.
- `out_valid`  output  1: `out_data` holds a finished result; high only in DONE.
- `out_ready`  input  1: the consumer takes the result.
- `out_data`  output  WIDTH: result register, driven directly from the register.
- `shift_left`  output  1: high in each SHIFT cycle of a left job.
- `shift_right`  output  1: high in each SHIFT cycle of a right job.
- `shift_clear`  output  1: one-cycle pulse in the cycle a clear job is accepted.
- `busy`  output  1: high whenever the state is not IDLE.

## Operation
- State machine states: IDLE, SHIFT, DONE.
- Internal registers:
  - `data_r` (WIDTH bits), driven to `out_data`.
  - `cnt_r` (CNT_W bits).
  - `dir_r` (1 bit).
- IDLE:
  - `in_ready`=1.
  - A job is accepted on a rising edge where `in_valid`=1 ("accept edge").
  - Accept with `in_clear`=1: `data_r`←0, next state DONE.
  - Accept with `in_clear`=0 and `in_count`=0: `data_r`←`in_data`, next state DONE. This is a pass-through.
  - Accept with `in_clear`=0 and `in_count`>0: `data_r`←`in_data`, `cnt_r`←`in_count`, `dir_r`←`in_dir`, next state SHIFT.
- SHIFT, on every edge:
  - Left job (`dir_r`=0): `data_r`←{`data_r`[WIDTH-2:0],0}.
  - Right job (`dir_r`=1): `data_r`←{0,`data_r`[WIDTH-1:1]}.
  - `cnt_r`←`cnt_r`−1.
  - If `cnt_r`=1 before the edge, next state DONE.
- Shifts are logical with zero fill; there is no rotation and no sign extension. A count ≥ `WIDTH` yields 0, and the block still takes the full count of cycles.
- DONE:
  - `out_valid`=1 and `data_r` holds steady.
  - On an edge with `out_ready`=1, next state IDLE.
  - `in_valid` is ignored outside IDLE; `in_ready`=0 there.
- Strobes are combinational from state and registers:
  - `shift_left` = SHIFT & !`dir_r`.
  - `shift_right` = SHIFT & `dir_r`.
  - `shift_clear` = IDLE & `in_valid` & `in_clear`.
  - `shift_left` and `shift_right` are never high together.
- Reset (asynchronous, any state, including mid-SHIFT or in DONE):
  - State goes to IDLE; `data_r`, `cnt_r` and `dir_r` go to 0.
  - Outputs: `out_valid`=0, `out_data`=0, `busy`=0, all strobes 0.
  - `in_ready`=1 during and after reset.
  - A job in progress is discarded with no output.

## Timing
- Edge numbering: the accept edge is E0, and the following edges are E1, E2, …
- Clear job, or count 0: DONE is entered at E0, so `out_valid` is high in the cycle after the accept edge. Latency is 1 cycle.
- Count n>0:
  - SHIFT is entered at E0.
  - Shifts happen at E1…En; `shift_left` or `shift_right` is high for exactly n cycles.
  - DONE is entered at En, so `out_valid` rises after En. Latency is n+1 cycles.
- Handshake back to IDLE: if `out_ready` is high in the first DONE cycle, IDLE is re-entered at the next edge, and `in_ready` is high the cycle after that.
- Best-case throughput: one job per n+2 cycles.
- `out_data` is stable throughout DONE, however long `out_ready` is held low.
- Reset asserted in the same cycle as an accept: reset wins and the job is dropped.

## Test plan
- Left shift: `in_data`=4'b1011, `in_dir`=0, `in_count`=1 → `shift_left` high for 1 cycle, then `out_valid` with `out_data`=4'b0110 two cycles after the accept edge.
- Right shift: `in_data`=4'b1011, `in_dir`=1, `in_count`=2 → `shift_right` high for 2 cycles, then `out_data`=4'b0010. Also `in_count`=0 with `in_data`=4'b1011 → `out_data`=4'b1011 one cycle after accept, with no strobes.
- Clear: `in_clear`=1 with `in_data`=4'b1111 and `in_count`=3 → `shift_clear` pulses once, then `out_data`=4'b0000 one cycle after accept, with no shift strobes.
- Overshift: `in_data`=4'b1111, `in_dir`=0, `in_count`=7 → 7 `shift_left` cycles, then `out_data`=0 with `out_valid` 8 cycles after accept.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `out_data` stay constant, `in_ready`=0, and a second `in_valid` is ignored. Then raise `out_ready` → IDLE next edge, and the second job is accepted.
- Reset mid-SHIFT: `in_count`=5, assert `reset` after 2 shifts → immediately `busy`=0, `out_data`=0, strobes 0, `in_ready`=1. A new job after release completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shift sequencer. It accepts one shift job over a valid/ready handshake and
// performs one bit position per clock. The finished word is then held on a valid/ready output.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             shift_left,
    output logic             shift_right,
    output logic             shift_clear,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dir_r;
    logic             accept;

    // Logical single-bit shifts with zero fill; no rotation, no sign extension.
    function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] d);
        return {d[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] shr1(input logic [WIDTH-1:0] d);
        return {1'b0, d[WIDTH-1:1]};
    endfunction

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_clear || (in_count == '0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job registers. A clear job loads zero, and a zero-count job passes the word through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
            cnt_r  <= '0;
            dir_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_clear) begin
                            data_r <= '0;
                        end else begin
                            data_r <= in_data;
                            if (in_count != '0) begin
                                cnt_r <= in_count;
                                dir_r <= in_dir;
                            end
                        end
                    end
                end
                SHIFT: begin
                    data_r <= dir_r ? shr1(data_r) : shl1(data_r);
                    cnt_r  <= cnt_r - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == IDLE);
        busy        = (state != IDLE);
        out_valid   = (state == DONE);
        shift_left  = (state == SHIFT) && !dir_r;
        shift_right = (state == SHIFT) && dir_r;
        shift_clear = accept && in_clear;
    end

    assign out_data = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer. It runs a table of jobs, followed by backpressure,
// mid-shift reset, and reset-versus-accept sequences.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic [2:0] in_count;
    logic       in_clear;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       shift_left;
    logic       shift_right;
    logic       shift_clear;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [2:0] count;
        logic       clr;
        logic [3:0] exp;
        int         nl;
        int         nr;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .in_count   (in_count),
        .in_clear   (in_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .shift_clear(shift_clear),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input vec_t v);
        int nl  = 0;
        int nr  = 0;
        int lat = 1;
        bit done = 1'b0;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_dir   = v.dir;
        in_count = v.count;
        in_clear = v.clr;
        #1 chk({tag, ".shift_clear"}, shift_clear, v.clr);
        @(negedge clk);
        in_valid = 1'b0;
        in_clear = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_valid) begin
                done = 1'b1;
            end else begin
                nl += int'(shift_left);
                nr += int'(shift_right);
                chk({tag, ".strobe_excl"}, shift_left & shift_right, 0);
                chk({tag, ".busy_work"}, busy, 1);
                lat++;
                @(negedge clk);
            end
        end
        chk({tag, ".done_seen"}, done, 1);
        chk({tag, ".latency"}, lat, v.lat);
        chk({tag, ".left_cycles"}, nl, v.nl);
        chk({tag, ".right_cycles"}, nr, v.nr);
        chk({tag, ".out_data"}, out_data, v.exp);
        chk({tag, ".in_ready_done"}, in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".out_valid_after"}, out_valid, 0);
        chk({tag, ".in_ready_after"}, in_ready, 1);
        chk({tag, ".busy_after"}, busy, 0);
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk({tag, ".valid_seen"}, seen, 1);
    endtask

    initial begin
        vecs[0] = '{data: 4'b1011, dir: 1'b0, count: 3'd1, clr: 1'b0, exp: 4'b0110, nl: 1, nr: 0, lat: 2};
        vecs[1] = '{data: 4'b1011, dir: 1'b1, count: 3'd2, clr: 1'b0, exp: 4'b0010, nl: 0, nr: 2, lat: 3};
        vecs[2] = '{data: 4'b1011, dir: 1'b1, count: 3'd0, clr: 1'b0, exp: 4'b1011, nl: 0, nr: 0, lat: 1};
        vecs[3] = '{data: 4'b1111, dir: 1'b0, count: 3'd3, clr: 1'b1, exp: 4'b0000, nl: 0, nr: 0, lat: 1};
        vecs[4] = '{data: 4'b1111, dir: 1'b0, count: 3'd7, clr: 1'b0, exp: 4'b0000, nl: 7, nr: 0, lat: 8};
        vecs[5] = '{data: 4'b1001, dir: 1'b1, count: 3'd7, clr: 1'b0, exp: 4'b0000, nl: 0, nr: 7, lat: 8};
        vecs[6] = '{data: 4'b0110, dir: 1'b1, count: 3'd1, clr: 1'b0, exp: 4'b0011, nl: 0, nr: 1, lat: 2};
        vecs[7] = '{data: 4'b0001, dir: 1'b0, count: 3'd3, clr: 1'b0, exp: 4'b1000, nl: 3, nr: 0, lat: 4};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        in_count  = '0;
        in_clear  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held, second job ignored until handshake.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0011; in_dir = 1'b0; in_count = 3'd1; in_clear = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; in_data = 4'b1000; in_dir = 1'b1; in_count = 3'd1;
            end
            chk("bp.out_valid_hold", out_valid, 1);
            chk("bp.out_data_hold", out_data, 4'b0110);
            chk("bp.in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.idle_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.second_shift_right", shift_right, 1);
        @(negedge clk);
        chk("bp.second_valid", out_valid, 1);
        chk("bp.second_data", out_data, 4'b0100);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset asserted after two of five left shifts.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b0; in_count = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 chk("mid.pre_out_data", out_data, 4'b1100);
        reset = 1'b1;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.out_data", out_data, 0);
        chk("mid.shift_left", shift_left, 0);
        chk("mid.shift_right", shift_right, 0);
        chk("mid.in_ready", in_ready, 1);
        chk("mid.out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        run_job("post_rst", vecs[1]);

        // Reset coincident with an accept edge drops the job.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0101; in_dir = 1'b0; in_count = 3'd2;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_acc.busy", busy, 0);
        chk("rst_acc.in_ready", in_ready, 1);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_acc.busy_after", busy, 0);
        chk("rst_acc.out_data", out_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
